gamma_prog_top: RTL and testbench

//   Programmable per-channel gamma correction for the ISP video stream.
//   - Each channel has a 2^DATA_W-entry LUT, double-buffered: active bank serves pixels, shadow bank is host-writable.
//   - Banks swap only at frame start (in_vsync rising edge), so a frame is never corrected with a mixed table.
//   - Sits after demosaic/colour blocks, before output formatting; generalises the fixed 8-bit RGB gamma stage.

---
 rtl/gamma_prog_if.sv | 39 +++
 rtl/gamma_prog_top.sv | 172 +++++++++++++++++
 tb/tb_gamma_prog_top.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gamma_prog_if.sv
// Video stream and host configuration bundle for the programmable gamma stage.
// master drives the pixel/config inputs; slave is the gamma block itself.
interface gamma_prog_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PIX_W = CHANNELS * DATA_W;

    logic              in_vsync;
    logic              in_hsync;
    logic              in_den;
    logic [PIX_W-1:0]  in_data;
    logic              out_vsync;
    logic              out_hsync;
    logic              out_den;
    logic [PIX_W-1:0]  out_data;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [DATA_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              cfg_swap;
    logic              cfg_busy;
    logic              cfg_active_bank;

    modport master (
        output in_vsync, in_hsync, in_den, in_data,
        output cfg_we, cfg_ch, cfg_addr, cfg_wdata, cfg_swap,
        input  out_vsync, out_hsync, out_den, out_data,
        input  cfg_busy, cfg_active_bank
    );

    modport slave (
        input  in_vsync, in_hsync, in_den, in_data,
        input  cfg_we, cfg_ch, cfg_addr, cfg_wdata, cfg_swap,
        output out_vsync, out_hsync, out_den, out_data,
        output cfg_busy, cfg_active_bank
    );
endinterface

// File: rtl/gamma_prog_top.sv
// Per-channel double-buffered gamma LUT with frame-aligned bank swap, latency 2.
// Optional GAMMA_BYPASS_EN adds a bypass input that forces identity through the LUT stage.
//
// state | meaning
// INIT  | fill both banks of every channel with identity, one entry per cycle
// IDLE  | tables live, no swap requested
// PEND  | swap requested, waiting for the next in_vsync rising edge
module gamma_prog_top #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3
) (
    input  logic        clk,
    input  logic        reset,
`ifdef GAMMA_BYPASS_EN
    input  logic        bypass,
`endif
    gamma_prog_if.slave bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DEPTH = 1 << DATA_W;
    localparam int PIX_W = CHANNELS * DATA_W;
    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] init_cnt_q, init_cnt_d;
    logic              bank_q, bank_d;

    logic              s1_vsync_q, s1_vsync_d;
    logic              s1_hsync_q, s1_hsync_d;
    logic              s1_den_q, s1_den_d;
    logic [PIX_W-1:0]  s1_data_q, s1_data_d;
    logic              s1_bank_q, s1_bank_d;
    logic              s1_pass_q, s1_pass_d;

    logic              out_vsync_q, out_vsync_d;
    logic              out_hsync_q, out_hsync_d;
    logic              out_den_q, out_den_d;
    logic [PIX_W-1:0]  out_data_q, out_data_d;

    logic              vsync_rise;
    logic              busy;
    logic              init_we;
    logic              cfg_hit;

    logic [DATA_W-1:0] lut_q [CHANNELS][2][DEPTH];

    // s1_vsync_q doubles as the previous-vsync register for edge detection
    assign vsync_rise = bus.in_vsync & ~s1_vsync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            bank_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            bank_q     <= bank_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        bank_d     = bank_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.cfg_swap) begin
                    if (vsync_rise) bank_d  = ~bank_q;
                    else            state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (vsync_rise) begin
                    bank_d  = ~bank_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        init_we = (state_q == ST_INIT);
        cfg_hit = bus.cfg_we && (state_q != ST_INIT) && ({1'b0, bus.cfg_ch} < CH_LIM);
    end

    // Host writes target the bank that is shadow before any same-cycle swap
    always_ff @(posedge clk) begin
        if (init_we) begin
            for (int c = 0; c < CHANNELS; c++) begin
                lut_q[c][0][init_cnt_q] <= init_cnt_q;
                lut_q[c][1][init_cnt_q] <= init_cnt_q;
            end
        end else if (cfg_hit) begin
            lut_q[bus.cfg_ch][~bank_q][bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    always_comb begin
        s1_vsync_d = bus.in_vsync;
        s1_hsync_d = bus.in_hsync;
        s1_den_d   = bus.in_den;
        s1_data_d  = bus.in_data;
        s1_bank_d  = bank_q;
`ifdef GAMMA_BYPASS_EN
        s1_pass_d  = init_we | bypass;
`else
        s1_pass_d  = init_we;
`endif
    end

    always_comb begin
        out_vsync_d = s1_vsync_q;
        out_hsync_d = s1_hsync_q;
        out_den_d   = s1_den_q;
        out_data_d  = s1_data_q;
        if (!s1_pass_q) begin
            for (int c = 0; c < CHANNELS; c++) begin
                out_data_d[c*DATA_W +: DATA_W] =
                    lut_q[c][s1_bank_q][s1_data_q[c*DATA_W +: DATA_W]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vsync_q  <= 1'b0;
            s1_hsync_q  <= 1'b0;
            s1_den_q    <= 1'b0;
            s1_data_q   <= '0;
            s1_bank_q   <= 1'b0;
            s1_pass_q   <= 1'b1;
            out_vsync_q <= 1'b0;
            out_hsync_q <= 1'b0;
            out_den_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_vsync_q  <= s1_vsync_d;
            s1_hsync_q  <= s1_hsync_d;
            s1_den_q    <= s1_den_d;
            s1_data_q   <= s1_data_d;
            s1_bank_q   <= s1_bank_d;
            s1_pass_q   <= s1_pass_d;
            out_vsync_q <= out_vsync_d;
            out_hsync_q <= out_hsync_d;
            out_den_q   <= out_den_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_vsync       = out_vsync_q;
    assign bus.out_hsync       = out_hsync_q;
    assign bus.out_den         = out_den_q;
    assign bus.out_data        = out_data_q;
    assign bus.cfg_busy        = busy;
    assign bus.cfg_active_bank = bank_q;
endmodule

// File: tb/tb_gamma_prog_top.sv
// Directed bench for gamma_prog_top: INIT timing, LUT swap, shadow writes, reset recovery.
module tb_gamma_prog_top;
    localparam int DATA_W   = 8;
    localparam int CHANNELS = 3;

    logic clk = 1'b0;
    logic reset;
    logic bypass;
    int   tests = 0;
    int   fails = 0;
    int   n;

    gamma_prog_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS)) bus ();

    gamma_prog_top #(.DATA_W(DATA_W), .CHANNELS(CHANNELS)) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef GAMMA_BYPASS_EN
        .bypass (bypass),
`endif
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int a2, input int a1, input int a0);
        return {a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic wait_init(output int cnt);
        cnt = 0;
        while (bus.cfg_busy === 1'b1 && cnt < 400) begin
            cnt++;
            tick();
        end
    endtask

    task automatic write_ch1_inverted();
        for (int i = 0; i < 256; i++) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_ch    = 2'd1;
            bus.cfg_addr  = 8'(i);
            bus.cfg_wdata = 8'(255 - i);
            tick();
        end
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bypass        = 1'b0;
        bus.in_vsync  = 1'b0;
        bus.in_hsync  = 1'b0;
        bus.in_den    = 1'b0;
        bus.in_data   = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.cfg_swap  = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_den", 32'(bus.out_den), 32'd0);
        chk("rst_out_vsync", 32'(bus.out_vsync), 32'd0);
        chk("rst_busy", 32'(bus.cfg_busy), 32'd1);
        chk("rst_bank", 32'(bus.cfg_active_bank), 32'd0);

        // INIT length, then identity ramp with lag 2
        reset = 1'b0;
        wait_init(n);
        chk("init_cycles", 32'(n), 32'd256);
        bus.in_den = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            if (i < 256) bus.in_data = pix(i, i, i);
            tick();
            if (i >= 1) chk("ramp", 32'(bus.out_data), 32'(pix(i - 1, i - 1, i - 1)));
        end
        chk("den_lag", 32'(bus.out_den), 32'd1);

        bus.in_hsync = 1'b1;
        tick();
        chk("hsync_lag1", 32'(bus.out_hsync), 32'd0);
        tick();
        chk("hsync_lag2", 32'(bus.out_hsync), 32'd1);
        bus.in_hsync = 1'b0;

        // inverted ch1 into shadow, swap at vsync
        write_ch1_inverted();
        bus.cfg_swap = 1'b1;
        tick();
        bus.cfg_swap = 1'b0;
        chk("pend_busy", 32'(bus.cfg_busy), 32'd1);
        chk("pend_bank", 32'(bus.cfg_active_bank), 32'd0);
        bus.in_vsync = 1'b1;
        tick();
        chk("swap_bank", 32'(bus.cfg_active_bank), 32'd1);
        chk("swap_busy", 32'(bus.cfg_busy), 32'd0);
        bus.in_data = pix(10, 10, 10);
        tick();
        tick();
        chk("inv_10", 32'(bus.out_data), 32'(pix(10, 245, 10)));
        bus.in_data = pix(0, 0, 0);
        tick();
        tick();
        chk("inv_0", 32'(bus.out_data), 32'(pix(0, 255, 0)));
        bus.in_data = pix(255, 255, 255);
        tick();
        tick();
        chk("inv_255", 32'(bus.out_data), 32'(pix(255, 0, 255)));
        bus.in_vsync = 1'b0;
        tick();

        // shadow write without swap stays invisible across frames
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 2'd0;
        bus.cfg_addr  = 8'd5;
        bus.cfg_wdata = 8'd99;
        tick();
        bus.cfg_we   = 1'b0;
        bus.in_data  = pix(5, 5, 5);
        tick();
        tick();
        chk("shadow_hidden", 32'(bus.out_data), 32'(pix(5, 250, 5)));
        bus.in_vsync = 1'b1;
        tick();
        bus.in_vsync = 1'b0;
        tick();
        chk("noswap_bank", 32'(bus.cfg_active_bank), 32'd1);
        chk("shadow_hidden2", 32'(bus.out_data), 32'(pix(5, 250, 5)));

        // swap request coincident with the vsync edge
        bus.cfg_swap = 1'b1;
        bus.in_vsync = 1'b1;
        tick();
        bus.cfg_swap = 1'b0;
        chk("same_cyc_bank", 32'(bus.cfg_active_bank), 32'd0);
        chk("same_cyc_busy", 32'(bus.cfg_busy), 32'd0);
        tick();
        tick();
        chk("bank0_entry5", 32'(bus.out_data), 32'(pix(5, 5, 99)));
        bus.in_vsync = 1'b0;
        tick();

        // repeated request while pending toggles only once
        bus.cfg_swap = 1'b1;
        tick();
        bus.cfg_swap = 1'b0;
        tick();
        bus.cfg_swap = 1'b1;
        tick();
        bus.cfg_swap = 1'b0;
        chk("dbl_pend_busy", 32'(bus.cfg_busy), 32'd1);
        chk("dbl_pend_bank", 32'(bus.cfg_active_bank), 32'd0);
        bus.in_vsync = 1'b1;
        tick();
        chk("dbl_bank", 32'(bus.cfg_active_bank), 32'd1);
        chk("dbl_busy", 32'(bus.cfg_busy), 32'd0);
        bus.in_vsync = 1'b0;
        tick();
        bus.in_vsync = 1'b1;
        tick();
        chk("dbl_no_retoggle", 32'(bus.cfg_active_bank), 32'd1);
        bus.in_vsync = 1'b0;
        tick();

        // reset mid-frame after swap
        bus.in_data = pix(10, 10, 10);
        tick();
        tick();
        chk("pre_rst_inv", 32'(bus.out_data), 32'(pix(10, 245, 10)));
        reset = 1'b1;
        tick();
        chk("midrst_data", 32'(bus.out_data), 32'd0);
        chk("midrst_den", 32'(bus.out_den), 32'd0);
        chk("midrst_bank", 32'(bus.cfg_active_bank), 32'd0);
        chk("midrst_busy", 32'(bus.cfg_busy), 32'd1);
        reset = 1'b0;
        bus.in_data = pix(8'h12, 8'h34, 8'h56);
        tick();
        tick();
        chk("init_passthru", 32'(bus.out_data), 32'(pix(8'h12, 8'h34, 8'h56)));
        wait_init(n);
        chk("reinit_done", 32'(bus.cfg_busy), 32'd0);
        bus.in_data = pix(10, 10, 10);
        tick();
        tick();
        chk("reinit_id10", 32'(bus.out_data), 32'(pix(10, 10, 10)));
        bus.in_data = pix(5, 5, 5);
        tick();
        tick();
        chk("reinit_id5", 32'(bus.out_data), 32'(pix(5, 5, 5)));

`ifdef GAMMA_BYPASS_EN
        write_ch1_inverted();
        bus.cfg_swap = 1'b1;
        bus.in_vsync = 1'b1;
        tick();
        bus.cfg_swap = 1'b0;
        bus.in_vsync = 1'b0;
        chk("byp_bank", 32'(bus.cfg_active_bank), 32'd1);
        bypass      = 1'b1;
        bus.in_data = pix(10, 10, 10);
        tick();
        tick();
        chk("byp_on", 32'(bus.out_data), 32'(pix(10, 10, 10)));
        bypass = 1'b0;
        tick();
        chk("byp_lag", 32'(bus.out_data), 32'(pix(10, 10, 10)));
        tick();
        chk("byp_off", 32'(bus.out_data), 32'(pix(10, 245, 10)));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
